// File: rtl/mult_div_if.sv
// ---------------------------------------------------------------------------
// mult_div_if
//   Bundle between the execute stage and the iterative multiply/divide unit.
//   master : issues operations and MTHI/MTLO writes, observes status/results
//   slave  : the multiply/divide unit
//
//   start      request an operation (sampled only while busy=0)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rsData     operand A (multiplicand / dividend)
//   rtData     operand B (multiplier / divisor)
//   hiWrite    MTHI: load writeData into HI
//   loWrite    MTLO: load writeData into LO
//   writeData  data for MTHI/MTLO
//   busy       operation in progress
//   done       one-cycle pulse, HI/LO just updated
//   divByZero  last accepted divide had rtData==0
//   hi, lo     architectural HI/LO registers
// ---------------------------------------------------------------------------
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rsData, rtData, hiWrite, loWrite, writeData,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, rsData, rtData, hiWrite, loWrite, writeData,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative MIPS multiply/divide unit. One shift-add (multiply) or one
//   restoring-subtract (divide) step per clock; signed operations run on
//   magnitudes and are sign-corrected in the final state before HI/LO are
//   written in a single edge.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   md     mult_div_if.slave (operation request, MTHI/MTLO, status, HI/LO)
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  mult_div_if.slave md
);

  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     opa_q, opa_d;      // |multiplicand|, or raw dividend on divide-by-zero
  logic [WIDTH-1:0]     opb_q, opb_d;      // |divisor|
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or dividend/quotient shifter in low half
  logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 op_is_div_s;
  logic                 op_signed_s;
  logic                 rs_neg_s;
  logic                 rt_neg_s;
  logic                 div_zero_s;
  logic [WIDTH-1:0]     rs_abs_s;
  logic [WIDTH-1:0]     rt_abs_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic                 div_ge_s;
  logic                 res_neg_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

  // Operand decode at accept: op[0]=0 selects the signed variants.
  assign op_is_div_s = md.op[1];
  assign op_signed_s = ~md.op[0];
  assign rs_neg_s    = op_signed_s & md.rsData[WIDTH-1];
  assign rt_neg_s    = op_signed_s & md.rtData[WIDTH-1];
  assign rs_abs_s    = rs_neg_s ? (-md.rsData) : md.rsData;
  assign rt_abs_s    = rt_neg_s ? (-md.rtData) : md.rtData;
  assign div_zero_s  = op_is_div_s & (md.rtData == {WIDTH{1'b0}});

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc[0]) is set; the carry is kept in the WIDTH+1 sum.
  assign mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});

  // Restoring step: shift next dividend bit into the remainder and try the
  // subtraction; a clear sign bit of the WIDTH+1 difference means it fits.
  assign div_shift_s = {rem_q, acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opb_q};
  assign div_ge_s    = ~div_diff_s[WIDTH];

  // Sign correction: product/quotient negate on differing signs, remainder
  // follows the dividend. Sign bits are already zero for unsigned ops.
  assign res_neg_s  = sign_a_q ^ sign_b_q;
  assign prod_fix_s = res_neg_s ? (-acc_q) : acc_q;
  assign quo_fix_s  = res_neg_s ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix_s  = sign_a_q ? (-rem_q) : rem_q;

  // Next-state, datapath step and HI/LO update.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          // Start wins over a simultaneous MTHI/MTLO.
          is_div_d = op_is_div_s;
          sign_a_d = rs_neg_s;
          sign_b_d = rt_neg_s;
          opa_d    = div_zero_s ? md.rsData : rs_abs_s;
          opb_d    = rt_abs_s;
          acc_d    = op_is_div_s ? {{WIDTH{1'b0}}, rs_abs_s}
                                 : {{WIDTH{1'b0}}, rt_abs_s};
          rem_d    = {WIDTH{1'b0}};
          cnt_d    = {CW{1'b0}};
          dbz_d    = div_zero_s;
          state_d  = div_zero_s ? S_FIN : S_RUN;
        end else begin
          if (md.hiWrite) begin
            hi_d = md.writeData;
          end else begin
            hi_d = hi_q;
          end
          if (md.loWrite) begin
            lo_d = md.writeData;
          end else begin
            lo_d = lo_q;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (is_div_q) begin
          rem_d = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge_s};
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dbz_q) begin
          hi_d = opa_q;
          lo_d = {WIDTH{1'b1}};
        end else if (is_div_q) begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign md.busy      = (state_q != S_IDLE);
  assign md.done      = done_q;
  assign md.divByZero = dbz_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed vectors for mult_div_unit. Each issued operation pushes its
//   hand-computed HI/LO/divByZero and latency into a scoreboard queue; a
//   monitor pops and compares whenever done is presented.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          acc_cyc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_id = 0;
  exp_t sb[$];

  mult_div_if #(.WIDTH(32)) md_if();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: compare every done pulse against the oldest expectation.
  initial begin
    int   busy_run;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else if (md_if.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_hi", e.id), {32'd0, md_if.hi}, {32'd0, e.hi});
          chk($sformatf("v%0d_lo", e.id), {32'd0, md_if.lo}, {32'd0, e.lo});
          chk($sformatf("v%0d_dbz", e.id), {63'd0, md_if.divByZero}, {63'd0, e.dbz});
          chk($sformatf("v%0d_latency", e.id), 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
          chk($sformatf("v%0d_busy_cycles", e.id), 64'(busy_run), 64'(e.lat - 1));
          chk($sformatf("v%0d_busy_at_done", e.id), {63'd0, md_if.busy}, 64'd0);
        end
        busy_run = 0;
      end else if (md_if.busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Called at a negedge; presents start for one edge and returns at the next negedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat);
    exp_t e;
    md_if.start  = 1'b1;
    md_if.op     = op;
    md_if.rsData = rs;
    md_if.rtData = rt;
    e.hi = eh;
    e.lo = el;
    e.dbz = ed;
    e.lat = lat;
    e.acc_cyc = cyc + 1;
    e.id = next_id;
    next_id++;
    sb.push_back(e);
    @(negedge clk);
    md_if.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (sb.size() != 0 || md_if.busy); i++) @(negedge clk);
    if (sb.size() != 0 || md_if.busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lo_before;
    md_if.start = 1'b0;
    md_if.op = 2'b00;
    md_if.rsData = 32'd0;
    md_if.rtData = 32'd0;
    md_if.hiWrite = 1'b0;
    md_if.loWrite = 1'b0;
    md_if.writeData = 32'd0;

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, md_if.busy}, 64'd0);
    chk("reset_done", {63'd0, md_if.done}, 64'd0);
    chk("reset_hi", {32'd0, md_if.hi}, 64'd0);
    chk("reset_lo", {32'd0, md_if.lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34); wait_idle();
    issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34); wait_idle();
    issue(OP_MULT,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0010, 1'b0, 34); wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34); wait_idle();
    issue(OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 34); wait_idle();
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34); wait_idle();
    issue(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34); wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 34); wait_idle();
    issue(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34); wait_idle();

    // Divide by zero, then a multiply clears the flag at accept.
    issue(OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 2); wait_idle();
    chk("dbz_holds", {63'd0, md_if.divByZero}, 64'd1);
    issue(OP_MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 34);
    chk("dbz_clear_on_accept", {63'd0, md_if.divByZero}, 64'd0);
    chk("busy_after_accept", {63'd0, md_if.busy}, 64'd1);
    wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 2); wait_idle();

    // start and MTLO while busy are ignored; LO holds its old value.
    lo_before = md_if.lo;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 34);
    repeat (4) @(negedge clk);
    md_if.start = 1'b1;
    md_if.op = OP_MULTU;
    md_if.rsData = 32'd7;
    md_if.rtData = 32'd7;
    md_if.loWrite = 1'b1;
    md_if.writeData = 32'h0000_DEAD;
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.loWrite = 1'b0;
    chk("lo_hold_while_busy", {32'd0, md_if.lo}, {32'd0, lo_before});
    wait_idle();

    // MTHI alone, then MTHI+MTLO together.
    md_if.hiWrite = 1'b1;
    md_if.writeData = 32'h0000_1234;
    @(negedge clk);
    md_if.hiWrite = 1'b0;
    chk("mthi_hi", {32'd0, md_if.hi}, 64'h1234);
    chk("mthi_lo_unchanged", {32'd0, md_if.lo}, 64'h0);
    md_if.hiWrite = 1'b1;
    md_if.loWrite = 1'b1;
    md_if.writeData = 32'h0000_ABCD;
    @(negedge clk);
    md_if.hiWrite = 1'b0;
    md_if.loWrite = 1'b0;
    chk("mthilo_hi", {32'd0, md_if.hi}, 64'hABCD);
    chk("mthilo_lo", {32'd0, md_if.lo}, 64'hABCD);

    // Start accepted on the same edge as MTHI: write is dropped.
    md_if.hiWrite = 1'b1;
    md_if.writeData = 32'h0000_5555;
    issue(OP_MULTU, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 34);
    md_if.hiWrite = 1'b0;
    chk("start_wins_hi", {32'd0, md_if.hi}, 64'hABCD);
    wait_idle();

    issue(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34); wait_idle();

    // Asynchronous reset mid-RUN: aborted op never completes.
    issue(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 34);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_busy", {63'd0, md_if.busy}, 64'd0);
    chk("async_rst_done", {63'd0, md_if.done}, 64'd0);
    chk("async_rst_hi", {32'd0, md_if.hi}, 64'd0);
    chk("async_rst_lo", {32'd0, md_if.lo}, 64'd0);
    chk("async_rst_dbz", {63'd0, md_if.divByZero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_MULTU, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 32'h0000_0009, 1'b0, 34); wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
